mem_stage: RTL and testbench

Memory stage of the ARM pipeline, directly downstream of the execute stage. Consumes the execute results (ALU result as address, Rm value as store data, memory/write-back enables, destination register). Performs word loads and stores against an internal data memory with a configurable access latency, stalling upstream via `mem_stall` while an access is in flight. Registers the results into the MEM/WB boundary for the write-back stage.

---
 rtl/mem_stage_pkg.sv | 13 +
 rtl/mem_stage_data_memory.sv | 21 ++
 rtl/mem_stage.sv | 102 ++++++++++
 tb/tb_mem_stage.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the memory stage.
package mem_stage_pkg;
  localparam int WORD_W    = 32;
  localparam int REG_IDX_W = 4;

  typedef enum logic {IDLE, BUSY} state_e;

  // Byte address to word offset relative to the mapped base; caller truncates.
  function automatic logic [WORD_W-1:0] addr_to_word(input logic [WORD_W-1:0] addr,
                                                     input logic [WORD_W-1:0] base);
    return (addr - base) >> 2;
  endfunction
endpackage

// File: rtl/mem_stage_data_memory.sv
// Word-wide data memory: asynchronous read, synchronous write, no reset.
module data_memory
  import mem_stage_pkg::*;
#(
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);
  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/mem_stage.sv
// ARM memory stage: multi-cycle word load/store with upstream stall and MEM/WB registers.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 rest,
  input  logic                 mem_r_en,
  input  logic                 mem_w_en,
  input  logic                 wb_en,
  input  logic [REG_IDX_W-1:0] dest,
  input  logic [WORD_W-1:0]    alu_res,
  input  logic [WORD_W-1:0]    val_rm,
  output logic                 mem_stall,
  output logic                 wb_en_out,
  output logic                 mem_r_en_out,
  output logic [REG_IDX_W-1:0] dest_out,
  output logic [WORD_W-1:0]    alu_res_out,
  output logic [WORD_W-1:0]    mem_data_out
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_cmd;
  logic              mem_we;
  logic [WORD_W-1:0] word_full;
  logic [AW-1:0]     idx;
  logic [WORD_W-1:0] rdata;
  logic              unused_idx_hi;

  assign mem_cmd       = mem_r_en | mem_w_en;
  assign word_full     = addr_to_word(alu_res, WORD_W'(BASE_ADDR));
  assign idx           = word_full[AW-1:0];
  assign unused_idx_hi = ^word_full[WORD_W-1:AW];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_stall = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_cmd && (WAIT_CYCLES > 0)) begin
          mem_stall = 1'b1;
          state_d   = BUSY;
          cnt_d     = CNT_INIT;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          mem_stall = 1'b1;
          cnt_d     = cnt_q - 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Write only on the completion edge, and never on a reset edge.
  assign mem_we = mem_w_en & ~mem_stall & rest;

  data_memory #(.DEPTH(DEPTH)) u_dmem (
    .clk     (clk),
    .we_i    (mem_we),
    .addr_i  (idx),
    .wdata_i (val_rm),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk) begin
    if (!rest) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      wb_en_out    <= 1'b0;
      mem_r_en_out <= 1'b0;
      dest_out     <= '0;
      alu_res_out  <= '0;
      mem_data_out <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!mem_stall) begin
        wb_en_out    <= wb_en;
        mem_r_en_out <= mem_r_en & ~mem_w_en;
        dest_out     <= dest;
        alu_res_out  <= alu_res;
        mem_data_out <= rdata;
      end else begin
        // Bubble so write-back never retires the stalled instruction twice.
        wb_en_out    <= 1'b0;
        mem_r_en_out <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench: one instance with WAIT_CYCLES=3, one single-cycle instance.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rest;
  logic        sel;
  logic        r_en, w_en, wb;
  logic [3:0]  dst;
  logic [31:0] alu, rm;

  logic        a_r, a_w, a_wb, b_r, b_w, b_wb;
  logic [3:0]  a_d, b_d;
  logic [31:0] a_alu, a_rm, b_alu, b_rm;
  logic        a_stall, a_wbo, a_ro, b_stall, b_wbo, b_ro;
  logic [3:0]  a_do, b_do;
  logic [31:0] a_ao, a_mo, b_ao, b_mo;

  logic        o_stall, o_wb, o_r;
  logic [3:0]  o_d;
  logic [31:0] o_a, o_m;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  assign a_r = sel ? 1'b0 : r_en;  assign b_r = sel ? r_en : 1'b0;
  assign a_w = sel ? 1'b0 : w_en;  assign b_w = sel ? w_en : 1'b0;
  assign a_wb = sel ? 1'b0 : wb;   assign b_wb = sel ? wb : 1'b0;
  assign a_d = dst; assign b_d = dst;
  assign a_alu = alu; assign b_alu = alu;
  assign a_rm = rm; assign b_rm = rm;

  assign o_stall = sel ? b_stall : a_stall;
  assign o_wb    = sel ? b_wbo : a_wbo;
  assign o_r     = sel ? b_ro : a_ro;
  assign o_d     = sel ? b_do : a_do;
  assign o_a     = sel ? b_ao : a_ao;
  assign o_m     = sel ? b_mo : a_mo;

  mem_stage #(.DEPTH(64), .BASE_ADDR(1024), .WAIT_CYCLES(3)) u_a (
    .clk(clk), .rest(rest), .mem_r_en(a_r), .mem_w_en(a_w), .wb_en(a_wb),
    .dest(a_d), .alu_res(a_alu), .val_rm(a_rm), .mem_stall(a_stall),
    .wb_en_out(a_wbo), .mem_r_en_out(a_ro), .dest_out(a_do),
    .alu_res_out(a_ao), .mem_data_out(a_mo));

  mem_stage #(.DEPTH(64), .BASE_ADDR(1024), .WAIT_CYCLES(0)) u_b (
    .clk(clk), .rest(rest), .mem_r_en(b_r), .mem_w_en(b_w), .wb_en(b_wb),
    .dest(b_d), .alu_res(b_alu), .val_rm(b_rm), .mem_stall(b_stall),
    .wb_en_out(b_wbo), .mem_r_en_out(b_ro), .dest_out(b_do),
    .alu_res_out(b_ao), .mem_data_out(b_mo));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    r_en = 1'b0; w_en = 1'b0; wb = 1'b0; dst = 4'd0; alu = 32'd0; rm = 32'd0;
  endtask

  // Drive one instruction, ride out its stall, return stall count; outputs valid on return.
  task automatic do_op(input logic r, input logic w, input logic b, input logic [3:0] d,
                       input logic [31:0] a, input logic [31:0] v, output int nst);
    r_en = r; w_en = w; wb = b; dst = d; alu = a; rm = v;
    nst = 0;
    #1;
    while (o_stall && nst < 16) begin
      nst++;
      tick();
      chk("bubble_wb", {31'd0, o_wb}, 32'd0);
      chk("bubble_r", {31'd0, o_r}, 32'd0);
    end
    if (nst >= 16) chk("stall_timeout", nst, 32'd0);
    tick();
    idle_in();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wb"}, {31'd0, o_wb}, 32'd0);
    chk({tag, "_r"}, {31'd0, o_r}, 32'd0);
    chk({tag, "_dest"}, {28'd0, o_d}, 32'd0);
    chk({tag, "_alu"}, o_a, 32'd0);
    chk({tag, "_data"}, o_m, 32'd0);
  endtask

  initial begin
    int ns;
    sel = 1'b0;
    idle_in();
    // Reset with a store request on the inputs.
    rest = 1'b0; w_en = 1'b1; alu = 32'd1028; rm = 32'h0BAD;
    tick(); tick();
    chk_zero("rst");
    rest = 1'b1; idle_in(); #1;
    chk("rst_stall", {31'd0, o_stall}, 32'd0);

    // Pass-through.
    wb = 1'b1; dst = 4'd5; alu = 32'h1234; #1;
    chk("pt_stall", {31'd0, o_stall}, 32'd0);
    tick(); idle_in(); #1;
    chk("pt_wb", {31'd0, o_wb}, 32'd1);
    chk("pt_dest", {28'd0, o_d}, 32'd5);
    chk("pt_alu", o_a, 32'h1234);
    chk("pt_r", {31'd0, o_r}, 32'd0);

    // Store then load, WAIT_CYCLES=3.
    do_op(1'b0, 1'b1, 1'b0, 4'd0, 32'd1028, 32'hDEADBEEF, ns);
    chk("st_stalls", ns, 32'd3);
    chk("st_wb", {31'd0, o_wb}, 32'd0);
    chk("st_alu", o_a, 32'd1028);
    do_op(1'b1, 1'b0, 1'b1, 4'd3, 32'd1028, 32'd0, ns);
    chk("ld_stalls", ns, 32'd3);
    chk("ld_data", o_m, 32'hDEADBEEF);
    chk("ld_r", {31'd0, o_r}, 32'd1);
    chk("ld_wb", {31'd0, o_wb}, 32'd1);
    chk("ld_dest", {28'd0, o_d}, 32'd3);

    // Index wraps modulo DEPTH: 1024+256 maps to word 0.
    do_op(1'b0, 1'b1, 1'b0, 4'd0, 32'd1024, 32'h11, ns);
    do_op(1'b1, 1'b0, 1'b1, 4'd1, 32'd1280, 32'd0, ns);
    chk("wrap_data", o_m, 32'h11);

    // Reset in the second stall cycle drops the in-flight store.
    do_op(1'b0, 1'b1, 1'b0, 4'd0, 32'd1032, 32'h33, ns);
    w_en = 1'b1; alu = 32'd1032; rm = 32'h22;
    tick();
    rest = 1'b0;
    tick();
    rest = 1'b1; idle_in(); #1;
    chk("mid_stall", {31'd0, o_stall}, 32'd0);
    chk_zero("mid");
    do_op(1'b1, 1'b0, 1'b1, 4'd2, 32'd1032, 32'd0, ns);
    chk("mid_data", o_m, 32'h33);
    chk("mid_stalls", ns, 32'd3);

    // Reset held with a store request does not write memory.
    do_op(1'b0, 1'b1, 1'b0, 4'd0, 32'd1036, 32'h77, ns);
    rest = 1'b0; w_en = 1'b1; alu = 32'd1036; rm = 32'h99;
    tick(); tick();
    rest = 1'b1; idle_in();
    do_op(1'b1, 1'b0, 1'b1, 4'd4, 32'd1036, 32'd0, ns);
    chk("rstw_data", o_m, 32'h77);

    // Single-cycle instance: back-to-back store/load and dual enable.
    sel = 1'b1; #1;
    do_op(1'b0, 1'b1, 1'b0, 4'd0, 32'd1028, 32'hA5A5A5A5, ns);
    chk("b_st_stalls", ns, 32'd0);
    do_op(1'b1, 1'b0, 1'b1, 4'd7, 32'd1028, 32'd0, ns);
    chk("b_ld_stalls", ns, 32'd0);
    chk("b_ld_data", o_m, 32'hA5A5A5A5);
    chk("b_ld_r", {31'd0, o_r}, 32'd1);
    chk("b_ld_dest", {28'd0, o_d}, 32'd7);
    do_op(1'b1, 1'b1, 1'b1, 4'd9, 32'd1032, 32'hC3, ns);
    chk("b_dual_stalls", ns, 32'd0);
    chk("b_dual_r", {31'd0, o_r}, 32'd0);
    chk("b_dual_wb", {31'd0, o_wb}, 32'd1);
    do_op(1'b1, 1'b0, 1'b1, 4'd9, 32'd1032, 32'd0, ns);
    chk("b_dual_data", o_m, 32'hC3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
